// File: rtl/vid_bus_pkg.sv
// vid_bus_pkg
//   Shared definitions for the video bus: command encodings, the memory
//   responder state encoding and burst-length helpers. Imported by the
//   frame-buffer responder and by the video controller.
package vid_bus_pkg;

  // Bus command encoding (3 bits on cmdin / cmdout).
  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_DATA  = 3'b001,
    CMD_READ  = 3'b010,
    CMD_RDATA = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_WRESP = 3'b101
  } vid_cmd_e;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_BID  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_BID  = 3'd4,
    ST_WR_RESP = 3'd5
  } resp_state_e;

  // Length code 00/01/10/11 -> 1/2/4/8 beats.
  function automatic logic [3:0] len_to_beats(input logic [1:0] len);
    return 4'd1 << len;
  endfunction

  // Beat-counter value of the final beat of a burst (beats - 1), sized for
  // the 3-bit beat counter.
  function automatic logic [2:0] len_to_last(input logic [1:0] len);
    logic [3:0] beats;
    beats = len_to_beats(len) - 4'd1;
    return beats[2:0];
  endfunction

endpackage

// File: rtl/vid_mem_array.sv
// vid_mem_array
//   DEPTH x 32-bit frame-buffer storage. One shared word address: the write
//   is synchronous, the read is combinational from the same address so the
//   responder can present a beat in the cycle its index is current.
// Ports:
//   clk    in   system clock
//   we     in   write enable, writes wdata to mem[addr] on the rising edge
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  mem[addr], combinational
module vid_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/vid_mem_resp.sv
// vid_mem_resp
//   Frame-buffer memory responder on the video bus. Serves READ bursts by
//   bidding for the bus and streaming data beats once granted, and accepts
//   WRITE bursts into the frame buffer followed by a single WRESP beat.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   selin        in   this target is selected for the current command
//   cmdin        in   bus command (see vid_bus_pkg::vid_cmd_e)
//   lenin        in   burst length code, valid with the command
//   addrdatain   in   byte address in the command cycle, data in data cycles
//   srcin        in   requesting initiator ID, valid with the command
//   ackin        in   arbiter grant, only looked at while bidding
//   reqout       out  bus bid (BID while bidding or driving a response)
//   lenout       out  burst length code echoed on response beats
//   addrdataout  out  read data, or start address on the write response
//   cmdout       out  response command
//   reqtar       out  initiator ID the response is addressed to
module vid_mem_resp
  import vid_bus_pkg::*;
#(
  parameter int         DEPTH = 1024,
  parameter logic [1:0] BID   = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic [3:0]  srcin,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic [2:0]  cmdout,
  output logic [3:0]  reqtar
);

  localparam int AW = $clog2(DEPTH);

  resp_state_e   state_q, state_d;
  logic [31:0]   addr_q, addr_d;   // captured start byte address
  logic [AW-1:0] idx_q, idx_d;     // current word index
  logic [1:0]    len_q, len_d;
  logic [3:0]    src_q, src_d;
  logic [2:0]    cnt_q, cnt_d;     // beats done so far in this burst

  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          is_last;
  logic          data_beat;

  vid_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (addrdatain),
    .rdata (mem_rdata)
  );

  assign is_last   = (cnt_q == len_to_last(len_q));
  assign data_beat = selin && (cmdin == CMD_DATA);

  // Next-state logic. The word index advances on every transferred beat and
  // wraps naturally at DEPTH because it is exactly AW bits wide.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (selin && (cmdin == CMD_READ || cmdin == CMD_WRITE)) begin
          addr_d  = addrdatain;
          idx_d   = addrdatain[AW+1:2];
          len_d   = lenin;
          src_d   = srcin;
          cnt_d   = 3'd0;
          state_d = (cmdin == CMD_READ) ? ST_RD_BID : ST_WR_DATA;
        end
      end

      ST_RD_BID: begin
        if (ackin) begin
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        idx_d = idx_q + 1'b1;
        if (is_last) begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_WR_DATA: begin
        // Anything other than a selected DATA beat is a stall; new READ or
        // WRITE commands here are dropped, not queued.
        if (data_beat) begin
          mem_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (is_last) begin
            cnt_d   = 3'd0;
            state_d = ST_WR_BID;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_WR_BID: begin
        if (ackin) begin
          state_d = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are a pure function of registered state, so a reset or the end
  // of a burst zeroes them in the very next cycle.
  always_comb begin
    reqout      = 2'b00;
    lenout      = 2'b00;
    addrdataout = 32'd0;
    cmdout      = CMD_IDLE;
    reqtar      = 4'd0;

    case (state_q)
      ST_RD_BID, ST_WR_BID: begin
        reqout = BID;
        reqtar = src_q;
      end

      ST_RD_DATA: begin
        reqout      = BID;
        reqtar      = src_q;
        lenout      = len_q;
        addrdataout = mem_rdata;
        cmdout      = (cnt_q == 3'd0) ? CMD_RDATA : CMD_DATA;
      end

      ST_WR_RESP: begin
        reqout      = BID;
        reqtar      = src_q;
        lenout      = len_q;
        addrdataout = addr_q;
        cmdout      = CMD_WRESP;
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      idx_q   <= '0;
      len_q   <= 2'b00;
      src_q   <= 4'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vid_mem_resp.sv
// tb_vid_mem_resp
//   Directed, table-driven bench for vid_mem_resp. Each table row is one
//   clock cycle: the inputs driven in that cycle and the outputs expected
//   during that cycle.
module tb_vid_mem_resp;

  localparam logic [2:0] C_IDLE  = 3'b000;
  localparam logic [2:0] C_DATA  = 3'b001;
  localparam logic [2:0] C_READ  = 3'b010;
  localparam logic [2:0] C_RDATA = 3'b011;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_WRESP = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic [3:0]  srcin;
  logic        ackin;
  logic [1:0]  reqout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic [2:0]  cmdout;
  logic [3:0]  reqtar;

  vid_mem_resp #(
    .DEPTH (1024),
    .BID   (2'b11)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .selin       (selin),
    .cmdin       (cmdin),
    .lenin       (lenin),
    .addrdatain  (addrdatain),
    .srcin       (srcin),
    .ackin       (ackin),
    .reqout      (reqout),
    .lenout      (lenout),
    .addrdataout (addrdataout),
    .cmdout      (cmdout),
    .reqtar      (reqtar)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic        sel;
    logic [2:0]  cmd;
    logic [1:0]  len;
    logic [31:0] ad;
    logic [3:0]  src;
    logic        ack;
    logic [1:0]  ereq;
    logic [1:0]  elen;
    logic [31:0] ead;
    logic [2:0]  ecmd;
    logic [3:0]  etar;
  } vec_t;

  vec_t  vecs[$];
  string tag;
  int    ntests = 0;
  int    nfail  = 0;

  function automatic vec_t mk(logic rst, logic sel, logic [2:0] cmd, logic [1:0] len,
                              logic [31:0] ad, logic [3:0] src, logic ack,
                              logic [1:0] ereq, logic [1:0] elen, logic [31:0] ead,
                              logic [2:0] ecmd, logic [3:0] etar);
    vec_t v;
    v.tag = tag; v.rst = rst; v.sel = sel; v.cmd = cmd; v.len = len;
    v.ad = ad; v.src = src; v.ack = ack;
    v.ereq = ereq; v.elen = elen; v.ead = ead; v.ecmd = ecmd; v.etar = etar;
    return v;
  endfunction

  // Row with full inputs, expected outputs all zero.
  function automatic void add_z(logic sel, logic [2:0] cmd, logic [1:0] len,
                                logic [31:0] ad, logic [3:0] src, logic ack);
    vecs.push_back(mk(1'b0, sel, cmd, len, ad, src, ack, 2'b00, 2'b00, 32'd0, C_IDLE, 4'd0));
  endfunction

  // Row while bidding: only reqout/reqtar active.
  function automatic void add_bid(logic ack, logic [3:0] tar);
    vecs.push_back(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, ack, 2'b11, 2'b00, 32'd0, C_IDLE, tar));
  endfunction

  // Row during a response beat.
  function automatic void add_beat(logic [1:0] elen, logic [31:0] ead, logic [2:0] ecmd, logic [3:0] tar);
    vecs.push_back(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b0, 2'b11, elen, ead, ecmd, tar));
  endfunction

  // Drive one row's inputs on the falling edge and compare the outputs that
  // the previous rising edge produced.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset      = v.rst;
    selin      = v.sel;
    cmdin      = v.cmd;
    lenin      = v.len;
    addrdatain = v.ad;
    srcin      = v.src;
    ackin      = v.ack;
    ntests++;
    if (reqout !== v.ereq || lenout !== v.elen || addrdataout !== v.ead ||
        cmdout !== v.ecmd || reqtar !== v.etar) begin
      nfail++;
      $display("FAIL %s row %0d: got req=%b len=%b ad=%h cmd=%b tar=%h, want req=%b len=%b ad=%h cmd=%b tar=%h",
               v.tag, idx, reqout, lenout, addrdataout, cmdout, reqtar,
               v.ereq, v.elen, v.ead, v.ecmd, v.etar);
    end else begin
      $display("[TB] %s row %0d: req=%b len=%b ad=%h cmd=%b tar=%h ok",
               v.tag, idx, reqout, lenout, addrdataout, cmdout, reqtar);
    end
  endtask

  initial begin
    reset = 1'b1; selin = 1'b0; cmdin = C_IDLE; lenin = 2'b00;
    addrdatain = 32'd0; srcin = 4'd0; ackin = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, then idle with ackin toggling (must be ignored in IDLE).
    tag = "reset";
    vecs.push_back(mk(1'b1, 1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b0, 2'b00, 2'b00, 32'd0, C_IDLE, 4'd0));
    tag = "idle";
    for (int i = 0; i < 10; i++) add_z(1'b0, C_READ, 2'b10, 32'h100, 4'h3, i[0]);

    // WRITE 0x100, 4 beats, two stall cycles between beats 2 and 3.
    tag = "write";
    add_z(1'b1, C_WRITE, 2'b10, 32'h100, 4'h5, 1'b0);
    add_z(1'b1, C_DATA, 2'b00, 32'h11, 4'h0, 1'b0);
    add_z(1'b1, C_DATA, 2'b00, 32'h22, 4'h0, 1'b0);
    add_z(1'b0, C_DATA, 2'b00, 32'h99, 4'h0, 1'b0);
    add_z(1'b1, C_IDLE, 2'b00, 32'h98, 4'h0, 1'b1);
    add_z(1'b1, C_DATA, 2'b00, 32'h33, 4'h0, 1'b0);
    add_z(1'b1, C_DATA, 2'b00, 32'h44, 4'h0, 1'b0);
    add_bid(1'b0, 4'h5);
    add_bid(1'b1, 4'h5);
    add_beat(2'b10, 32'h100, C_WRESP, 4'h5);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b0);

    // READ 0x100, grant after 3 waiting cycles.
    tag = "read";
    add_z(1'b1, C_READ, 2'b10, 32'h100, 4'hA, 1'b0);
    for (int i = 0; i < 3; i++) add_bid(1'b0, 4'hA);
    add_bid(1'b1, 4'hA);
    add_beat(2'b10, 32'h11, C_RDATA, 4'hA);
    add_beat(2'b10, 32'h22, C_DATA, 4'hA);
    add_beat(2'b10, 32'h33, C_DATA, 4'hA);
    add_beat(2'b10, 32'h44, C_DATA, 4'hA);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b0);

    // 8-beat WRITE at 0xFF8: words 1022, 1023, 0..5.
    tag = "wrap_wr";
    add_z(1'b1, C_WRITE, 2'b11, 32'hFF8, 4'h3, 1'b0);
    for (int i = 0; i < 8; i++) add_z(1'b1, C_DATA, 2'b00, 32'hC0DE_0000 + i, 4'h0, 1'b0);
    add_bid(1'b1, 4'h3);
    add_beat(2'b11, 32'hFF8, C_WRESP, 4'h3);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b0);

    tag = "wrap_rd";
    add_z(1'b1, C_READ, 2'b11, 32'hFF8, 4'h7, 1'b0);
    add_bid(1'b1, 4'h7);
    for (int i = 0; i < 8; i++) add_beat(2'b11, 32'hC0DE_0000 + i, (i == 0) ? C_RDATA : C_DATA, 4'h7);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b0);

    // Byte address 0x1001 -> word 0 (high bits and addr[1:0] ignored).
    tag = "word0";
    add_z(1'b1, C_READ, 2'b01, 32'h1001, 4'h1, 1'b0);
    add_bid(1'b1, 4'h1);
    add_beat(2'b01, 32'hC0DE_0002, C_RDATA, 4'h1);
    add_beat(2'b01, 32'hC0DE_0003, C_DATA, 4'h1);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b0);

    // READ arriving during WR_DATA and WR_BID is dropped.
    tag = "rd_in_wr";
    add_z(1'b1, C_WRITE, 2'b01, 32'h200, 4'h6, 1'b0);
    add_z(1'b1, C_DATA, 2'b00, 32'hAAAA, 4'h0, 1'b0);
    add_z(1'b1, C_READ, 2'b10, 32'h100, 4'hA, 1'b0);
    add_z(1'b1, C_DATA, 2'b00, 32'hBBBB, 4'h0, 1'b0);
    vecs.push_back(mk(1'b0, 1'b1, C_READ, 2'b10, 32'h100, 4'hA, 1'b1, 2'b11, 2'b00, 32'd0, C_IDLE, 4'h6));
    add_beat(2'b01, 32'h200, C_WRESP, 4'h6);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b0);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b1);

    tag = "rd_back";
    add_z(1'b1, C_READ, 2'b01, 32'h200, 4'h6, 1'b0);
    add_bid(1'b1, 4'h6);
    add_beat(2'b01, 32'hAAAA, C_RDATA, 4'h6);
    add_beat(2'b01, 32'hBBBB, C_DATA, 4'h6);
    add_z(1'b0, C_IDLE, 2'b00, 32'h0, 4'h0, 1'b0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand-written: reset during beat 2 of a read, then a fresh read.
    tag = "rst_mid";
    apply(mk(1'b0, 1'b1, C_READ, 2'b10, 32'h100, 4'h9, 1'b0, 2'b00, 2'b00, 32'd0, C_IDLE, 4'h0), 0);
    apply(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'h0, 1'b1, 2'b11, 2'b00, 32'd0, C_IDLE, 4'h9), 1);
    apply(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'h0, 1'b0, 2'b11, 2'b10, 32'h11, C_RDATA, 4'h9), 2);
    apply(mk(1'b1, 1'b0, C_IDLE, 2'b00, 32'd0, 4'h0, 1'b0, 2'b11, 2'b10, 32'h22, C_DATA, 4'h9), 3);
    apply(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'h0, 1'b0, 2'b00, 2'b00, 32'd0, C_IDLE, 4'h0), 4);
    apply(mk(1'b0, 1'b1, C_READ, 2'b00, 32'h100, 4'h2, 1'b0, 2'b00, 2'b00, 32'd0, C_IDLE, 4'h0), 5);
    apply(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'h0, 1'b1, 2'b11, 2'b00, 32'd0, C_IDLE, 4'h2), 6);
    apply(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'h0, 1'b0, 2'b11, 2'b00, 32'h11, C_RDATA, 4'h2), 7);
    apply(mk(1'b0, 1'b0, C_IDLE, 2'b00, 32'd0, 4'h0, 1'b0, 2'b00, 2'b00, 32'd0, C_IDLE, 4'h0), 8);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
